// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver: start, 7 data bits LSB first, even parity, stop.
// Presents each character with parity/framing status through a level/clear handshake.
module rx_serial_7e1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = 217
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    input  logic       limpa,
    output logic [6:0] dados_ascii,
    output logic       tem_dado,
    output logic       pronto,
    output logic       erro_paridade,
    output logic       erro_frame,
    output logic       overrun,
    output logic [3:0] db_estado
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        PREPARA  = 4'd1,
        START    = 4'd2,
        DADOS    = 4'd3,
        PARIDADE = 4'd4,
        STOP     = 4'd5,
        ARMAZENA = 4'd6,
        ESPERA   = 4'd7
    } state_t;

    state_t        state;
    logic          sync1, s;
    logic [CW-1:0] cnt;
    logic [2:0]    nbits;
    logic [6:0]    shreg;
    logic          par_bit, stop_bit;

    // Synchronizer flops reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
        end else begin
            sync1 <= dado_serial;
            s     <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= INICIAL;
            cnt           <= '0;
            nbits         <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            stop_bit      <= 1'b0;
            dados_ascii   <= '0;
            tem_dado      <= 1'b0;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_frame    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            pronto <= 1'b0;
            if (limpa)
                tem_dado <= 1'b0;
            case (state)
                INICIAL:
                    if (s) state <= PREPARA;
                PREPARA:
                    if (!s) begin
                        cnt   <= '0;
                        state <= START;
                    end
                START:
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        nbits <= '0;
                        state <= s ? PREPARA : DADOS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                DADOS:
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        shreg <= {s, shreg[6:1]};
                        nbits <= nbits + 1'b1;
                        if (nbits == 3'd6)
                            state <= PARIDADE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                PARIDADE:
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        par_bit <= s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                STOP:
                    if (cnt == BIT_END) begin
                        cnt      <= '0;
                        stop_bit <= s;
                        state    <= ARMAZENA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                ARMAZENA: begin
                    // Store overrides a simultaneous limpa; overrun sees the pre-edge tem_dado.
                    dados_ascii   <= shreg;
                    erro_paridade <= ^{shreg, par_bit};
                    erro_frame    <= ~stop_bit;
                    pronto        <= 1'b1;
                    overrun       <= overrun | tem_dado;
                    tem_dado      <= 1'b1;
                    state         <= stop_bit ? PREPARA : ESPERA;
                end
                ESPERA:
                    if (s) state <= PREPARA;
                default:
                    state <= INICIAL;
            endcase
        end
    end

    assign db_estado = state;
endmodule

// File: tb/tb_rx_serial_7e1.sv
// Directed bench for rx_serial_7e1 with CLKS_PER_BIT=8, HALF_BIT=4.
// Inputs change 1 time unit after the rising edge; outputs are read there or on the falling edge.
module tb_rx_serial_7e1;
    localparam int CPB = 8;
    localparam int HB  = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dado_serial = 1'b1;
    logic       limpa = 1'b0;
    logic [6:0] dados_ascii;
    logic       tem_dado, pronto, erro_paridade, erro_frame, overrun;
    logic [3:0] db_estado;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pronto_cnt = 0;
    int pronto_cyc = 0;
    int start_cyc = 0;
    int p0 = 0;
    logic [31:0] seq_w = '0;
    logic [3:0]  last_st = 4'hF;

    rx_serial_7e1 #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB)) dut (
        .clock(clock), .reset(reset), .dado_serial(dado_serial), .limpa(limpa),
        .dados_ascii(dados_ascii), .tem_dado(tem_dado), .pronto(pronto),
        .erro_paridade(erro_paridade), .erro_frame(erro_frame), .overrun(overrun),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Count pronto pulses and keep a nibble history of every state change.
    always @(negedge clock) begin
        if (pronto === 1'b1) begin
            pronto_cnt++;
            pronto_cyc = cyc;
        end
        if (db_estado !== last_st) begin
            seq_w   = {seq_w[27:0], db_estado};
            last_st = db_estado;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] d, input logic par, input logic stp, input int stop_cyc);
        start_cyc   = cyc;
        dado_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 7; i++) begin
            dado_serial = d[i];
            tick(CPB);
        end
        dado_serial = par;
        tick(CPB);
        dado_serial = stp;
        tick(stop_cyc);
    endtask

    task automatic pulse_limpa();
        limpa = 1'b1;
        tick(1);
        limpa = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_ascii", 32'(dados_ascii), 32'h0);
        check("rst_tem", 32'(tem_dado), 32'h0);
        check("rst_pronto", 32'(pronto), 32'h0);
        check("rst_flags", 32'({erro_paridade, erro_frame, overrun}), 32'h0);
        check("rst_state", 32'(db_estado), 32'h0);
        reset = 1'b0;
        tick(3);
        check("idle_state", 32'(db_estado), 32'h1);

        // 1: 'A' = 0x41, parity 0, stop 1
        p0 = pronto_cnt;
        send(7'h41, 1'b0, 1'b1, CPB);
        tick(2);
        check("A_pronto", 32'(pronto_cnt - p0), 32'd1);
        // One cycle from drive to the first sampling edge, then 2+1+4+9*8 = 79.
        check("A_latency", 32'(pronto_cyc - start_cyc), 32'd80);
        check("A_ascii", 32'(dados_ascii), 32'h41);
        check("A_tem", 32'(tem_dado), 32'h1);
        check("A_flags", 32'({erro_paridade, erro_frame, overrun}), 32'h0);
        check("A_states", 32'(seq_w[23:0]), 32'h234561);
        pulse_limpa();
        check("A_limpa", 32'(tem_dado), 32'h0);

        // 2: 'C' = 0x43 with wrong parity 0
        send(7'h43, 1'b0, 1'b1, CPB);
        tick(2);
        check("C_ascii", 32'(dados_ascii), 32'h43);
        check("C_perr", 32'(erro_paridade), 32'h1);
        check("C_ferr", 32'(erro_frame), 32'h0);
        check("C_tem", 32'(tem_dado), 32'h1);
        pulse_limpa();
        check("C_limpa", 32'(tem_dado), 32'h0);

        // 3: 0x55 with stop 0, line low for 20 cycles
        p0 = pronto_cnt;
        send(7'h55, 1'b0, 1'b0, 20);
        check("F_pronto", 32'(pronto_cnt - p0), 32'd1);
        check("F_state", 32'(db_estado), 32'h7);
        check("F_ferr", 32'(erro_frame), 32'h1);
        check("F_perr", 32'(erro_paridade), 32'h0);
        check("F_ascii", 32'(dados_ascii), 32'h55);
        dado_serial = 1'b1;
        tick(4);
        check("F_recover", 32'(db_estado), 32'h1);
        check("F_states", 32'(seq_w[11:0]), 32'h671);
        pulse_limpa();
        send(7'h2A, 1'b1, 1'b1, CPB);
        tick(2);
        check("F2_ascii", 32'(dados_ascii), 32'h2A);
        check("F2_flags", 32'({erro_paridade, erro_frame, overrun}), 32'h0);
        pulse_limpa();

        // 4: 2-cycle glitch on an idle line
        p0 = pronto_cnt;
        dado_serial = 1'b0;
        tick(2);
        dado_serial = 1'b1;
        tick(10);
        check("G_pronto", 32'(pronto_cnt - p0), 32'd0);
        check("G_state", 32'(db_estado), 32'h1);
        check("G_states", 32'(seq_w[7:0]), 32'h21);
        check("G_ascii", 32'(dados_ascii), 32'h2A);
        check("G_out", 32'({tem_dado, erro_paridade, erro_frame, overrun}), 32'h0);

        // 5: 0x11 then 0x22 back-to-back, no limpa
        p0 = pronto_cnt;
        send(7'h11, 1'b0, 1'b1, CPB);
        send(7'h22, 1'b0, 1'b1, CPB);
        tick(2);
        check("O_pronto", 32'(pronto_cnt - p0), 32'd2);
        check("O_ascii", 32'(dados_ascii), 32'h22);
        check("O_overrun", 32'(overrun), 32'h1);
        check("O_tem", 32'(tem_dado), 32'h1);
        pulse_limpa();
        check("O_limpa_tem", 32'(tem_dado), 32'h0);
        check("O_sticky", 32'(overrun), 32'h1);

        // 6: reset in the middle of a data bit
        p0 = pronto_cnt;
        dado_serial = 1'b0;
        tick(CPB);
        dado_serial = 1'b1;
        tick(CPB);
        dado_serial = 1'b0;
        tick(CPB + 3);
        check("R_pre_state", 32'(db_estado), 32'h3);
        dado_serial = 1'b1;
        reset = 1'b1;
        tick(1);
        check("R_ascii", 32'(dados_ascii), 32'h0);
        check("R_out", 32'({tem_dado, pronto, erro_paridade, erro_frame, overrun}), 32'h0);
        check("R_state", 32'(db_estado), 32'h0);
        reset = 1'b0;
        tick(2 * CPB);
        check("R_nopronto", 32'(pronto_cnt - p0), 32'd0);
        send(7'h7F, 1'b1, 1'b1, CPB);
        tick(2);
        check("R2_pronto", 32'(pronto_cnt - p0), 32'd1);
        check("R2_ascii", 32'(dados_ascii), 32'h7F);
        check("R2_out", 32'({tem_dado, erro_paridade, erro_frame, overrun}), 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
